error_countdown: RTL and testbench

ERROR_COUNTDOWN -- requirements
Module: error_countdown

---
 rtl/error_countdown.sv | 137 +++++++++++++
 tb/tb_error_countdown.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/error_countdown.sv
// error_countdown: timeout watchdog for the central FSM's calc-error state.
//
// When the FSM enters ERR_STATE a countdown of COUNT_SEC seconds starts
// (one second = CLK_FREQ cycles). If the FSM is still in ERR_STATE when the
// countdown expires, a single-cycle error_timeout pulse is issued. Leaving
// ERR_STATE aborts the countdown silently; re-entering restarts it.
//
// Optional feature macro: ERROR_COUNTDOWN_BLINK_EN
//   defined   - blink toggles every half second while counting
//   undefined - blink is tied to 0 and no blink logic exists
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   current_state in   [3:0] central FSM state code
//   error_timeout out  one-cycle pulse on countdown expiry
//   counting      out  high while a countdown is running
//   sec_left      out  [3:0] whole seconds remaining
//   blink         out  LED blink drive

module error_countdown #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned COUNT_SEC = 5,
    parameter logic [3:0]  ERR_STATE = 4'd12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] current_state,
    output logic       error_timeout,
    output logic       counting,
    output logic [3:0] sec_left,
    output logic       blink
);

    localparam int unsigned PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_FREQ - 1);
    localparam logic [3:0]    COUNT_INIT = 4'(COUNT_SEC);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [3:0]    prev_state_q;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [3:0]    sec_left_q, sec_left_d;
    logic          error_timeout_q, error_timeout_d;

    logic entry;
    logic in_err;
    logic tick;

    always_comb begin
        in_err = (current_state == ERR_STATE);
        entry  = in_err && (prev_state_q != ERR_STATE);
        tick   = (prescaler_q == PRE_MAX);
    end

    // Next-state: entry always reloads, abort beats a coincident tick.
    always_comb begin
        state_d         = state_q;
        prescaler_d     = '0;
        sec_left_d      = '0;
        error_timeout_d = 1'b0;
        if (entry) begin
            state_d    = StRun;
            sec_left_d = COUNT_INIT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRun: begin
                    if (!in_err) begin
                        state_d = StIdle;
                    end else if (tick) begin
                        if (sec_left_q > 4'd1) begin
                            sec_left_d = sec_left_q - 4'd1;
                        end else begin
                            state_d         = StIdle;
                            error_timeout_d = 1'b1;
                        end
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                        sec_left_d  = sec_left_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            prev_state_q    <= 4'd0;
            prescaler_q     <= '0;
            sec_left_q      <= 4'd0;
            error_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_state_q    <= current_state;
            prescaler_q     <= prescaler_d;
            sec_left_q      <= sec_left_d;
            error_timeout_q <= error_timeout_d;
        end
    end

`ifdef ERROR_COUNTDOWN_BLINK_EN
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_FREQ / 2 - 1);

    logic blink_q, blink_d;

    // Restarts low on entry and is forced low whenever the countdown stops.
    always_comb begin
        blink_d = 1'b0;
        if ((state_d == StRun) && !entry) begin
            blink_d = ((prescaler_q == PRE_HALF) || tick) ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

    assign error_timeout = error_timeout_q;
    assign counting      = (state_q == StRun);
    assign sec_left      = sec_left_q;

endmodule

// File: tb/tb_error_countdown.sv
// Directed bench for error_countdown at CLK_FREQ=10, COUNT_SEC=3, ERR_STATE=12.
// Cycle k counts from the first cycle with counting==1 (k=0).

module tb_error_countdown;

    localparam int unsigned CLK_FREQ  = 10;
    localparam int unsigned COUNT_SEC = 3;
    localparam logic [3:0]  ERR       = 4'd12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] current_state = 4'd0;
    logic       error_timeout;
    logic       counting;
    logic [3:0] sec_left;
    logic       blink;

    int n_vec  = 0;
    int n_miss = 0;

    error_countdown #(
        .CLK_FREQ  (CLK_FREQ),
        .COUNT_SEC (COUNT_SEC),
        .ERR_STATE (ERR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .error_timeout (error_timeout),
        .counting      (counting),
        .sec_left      (sec_left),
        .blink         (blink)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_blink(input int k);
`ifdef ERROR_COUNTDOWN_BLINK_EN
        return ((k / 5) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, ".counting"}, 32'(counting), 32'd0);
        check_eq({tag, ".sec_left"}, 32'(sec_left), 32'd0);
        check_eq({tag, ".timeout"}, 32'(error_timeout), 32'd0);
        check_eq({tag, ".blink"}, 32'(blink), 32'd0);
    endtask

    // Checks cycles from_k..to_k of a running countdown, leaving us at to_k+1.
    task automatic expect_run(input int from_k, input int to_k, input string tag);
        for (int k = from_k; k <= to_k; k++) begin
            check_eq({tag, ".counting"}, 32'(counting), 32'd1);
            check_eq({tag, ".sec_left"}, 32'(sec_left), 32'(COUNT_SEC - k / CLK_FREQ));
            check_eq({tag, ".timeout"}, 32'(error_timeout), 32'd0);
            check_eq({tag, ".blink"}, 32'(blink), 32'(exp_blink(k)));
            step();
        end
    endtask

    task automatic check_pulse(input string tag);
        check_eq({tag, ".timeout"}, 32'(error_timeout), 32'd1);
        check_eq({tag, ".counting"}, 32'(counting), 32'd0);
        check_eq({tag, ".sec_left"}, 32'(sec_left), 32'd0);
        check_eq({tag, ".blink"}, 32'(blink), 32'd0);
        step();
        check_eq({tag, ".one_cycle"}, 32'(error_timeout), 32'd0);
    endtask

    // Moves from a non-error state into ERR; returns at k=0.
    task automatic enter_err();
        current_state = 4'd0;
        step();
        current_state = ERR;
        step();
    endtask

    task automatic count_pulses(input int cycles, input int exp, input string tag);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (error_timeout) pulses++;
            step();
        end
        check_eq(tag, 32'(pulses), 32'(exp));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        current_state = 4'd0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        // Basic countdown, then hold ERR: exactly one pulse total
        enter_err();
        expect_run(0, 29, "basic");
        check_pulse("basic_expire");
        count_pulses(200, 0, "hold_no_repulse");
        check_idle("hold_idle");

        // Abort at cycle 15
        enter_err();
        expect_run(0, 14, "abort");
        current_state = 4'd8;
        step();
        check_idle("abort_next");
        count_pulses(100, 0, "abort_no_pulse");

        // Early retry: leave at 12, return at 13
        current_state = ERR;
        step();
        expect_run(0, 11, "retry_first");
        current_state = 4'd9;
        step();
        check_eq("retry_gap.counting", 32'(counting), 32'd0);
        current_state = ERR;
        step();
        expect_run(0, 29, "retry_second");
        check_pulse("retry_expire");

        // Abort coinciding with the final tick wins: no pulse
        enter_err();
        expect_run(0, 28, "abort_tick");
        current_state = 4'd0;
        step();
        check_idle("abort_tick_next");
        count_pulses(20, 0, "abort_tick_no_pulse");

        // Reset mid-countdown, release with ERR held -> fresh countdown
        enter_err();
        expect_run(0, 24, "rst_mid");
        rst = 1'b1;
        step();
        check_idle("rst_mid_cancel");
        count_pulses(3, 0, "rst_hold_no_pulse");
        rst = 1'b0;
        step();
        expect_run(0, 29, "rst_reentry");
        check_pulse("rst_reentry_expire");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
